// File: rtl/mod461_accum_if.sv
// Residue stream in / result out handshake bundle
// for the mod-461 accumulator.
interface mod461_accum_if #(
  parameter int W = 9
);
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    output out_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    input  out_ready
  );
endinterface

// File: rtl/mod461_accum.sv
// Sums n_terms residues modulo MOD, one term per
// accepted handshake, and presents the registered result.
module mod461_accum #(
  parameter int MOD   = 461,
  parameter int W     = 9,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] n_terms,
  mod461_accum_if.slave    bus,
  output logic             busy,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [W:0] MOD_L = (W+1)'(MOD);

  state_t           state_q, state_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [W:0]       din_x;
  logic             oor;
  logic [W:0]       t_x;
  logic [W:0]       sum;
  logic [W:0]       sum_red;
  logic             accept;

  // Terms >= MOD are folded once; W bits cap them below 2*MOD.
  assign din_x   = {1'b0, bus.in_data};
  assign oor     = (din_x >= MOD_L);
  assign t_x     = oor ? (din_x - MOD_L) : din_x;
  assign sum     = {1'b0, acc_q} + t_x;
  assign sum_red = (sum >= MOD_L) ? (sum - MOD_L) : sum;

  assign accept  = (state_q == ACCUM) && bus.in_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d = '0;
          err_d = 1'b0;
          cnt_d = n_terms;
          if (n_terms != '0) begin
            state_d = ACCUM;
          end else begin
            state_d = DONE;
          end
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_d = sum_red[W-1:0];
          cnt_d = cnt_q - CNT_W'(1);
          if (oor) begin
            err_d = 1'b1;
          end
          if (cnt_q == CNT_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = acc_q;
  assign busy          = (state_q != IDLE);
  assign err           = err_q;

endmodule

// File: tb/tb_mod461_accum.sv
// Directed vector bench for mod461_accum: table of
// jobs plus hand sequences for reset, zero-length and stall.
module tb_mod461_accum;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] n_terms;
  logic       busy;
  logic       err;

  int total;
  int passed;

  mod461_accum_if #(.W(9)) bus ();

  mod461_accum dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .n_terms (n_terms),
    .bus     (bus),
    .busy    (busy),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]       n;
    logic [15:0][8:0] t;
    logic             gaps;
    logic [8:0]       exp_d;
    logic             exp_e;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fill(input int i, input int n, input bit g,
                      input int tv, input int d, input bit e);
    vecs[i] = '0;
    vecs[i].n = 4'(n);
    vecs[i].gaps = g;
    vecs[i].exp_d = 9'(d);
    vecs[i].exp_e = e;
    for (int k = 0; k < 16; k++) vecs[i].t[k] = 9'(tv);
  endtask

  // Entered and left at #1 after a rising edge, DUT in IDLE.
  task automatic run_job(input vec_t v, input string tag);
    start = 1'b1;
    n_terms = v.n;
    @(negedge clk);
    chk({tag, "_idle_rdy"}, int'(bus.in_ready), 0);
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy"}, int'(busy), 1);
    chk({tag, "_err_clr"}, int'(err), 0);
    for (int k = 0; k < int'(v.n); k++) begin
      int g;
      g = v.gaps ? int'($urandom_range(0, 2)) : 0;
      repeat (g) begin
        bus.in_valid = 1'b0;
        bus.in_data = 9'(k * 37);
        @(negedge clk);
        chk({tag, "_gap_rdy"}, int'(bus.in_ready), 1);
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data = v.t[k];
      @(negedge clk);
      chk({tag, "_acc_rdy"}, int'(bus.in_ready), 1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_data = '0;
    end
    chk({tag, "_ovalid"}, int'(bus.out_valid), 1);
    chk({tag, "_odata"}, int'(bus.out_data), int'(v.exp_d));
    chk({tag, "_err"}, int'(err), int'(v.exp_e));
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, "_ovalid_drop"}, int'(bus.out_valid), 0);
    chk({tag, "_idle_busy"}, int'(busy), 0);
    chk({tag, "_err_hold"}, int'(err), int'(v.exp_e));
  endtask

  vec_t hv;

  initial begin
    total = 0;
    passed = 0;
    rst = 1'b1;
    start = 1'b0;
    n_terms = '0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;

    fill(0, 3, 1'b0, 0, 460, 1'b0);
    vecs[0].t[0] = 9'd460;
    vecs[0].t[1] = 9'd460;
    vecs[0].t[2] = 9'd1;
    fill(1, 9, 1'b1, 100, 439, 1'b0);
    fill(2, 2, 1'b0, 0, 39, 1'b1);
    vecs[2].t[0] = 9'd500;
    fill(3, 1, 1'b0, 0, 0, 1'b0);
    fill(4, 4, 1'b1, 0, 4, 1'b0);
    vecs[4].t[0] = 9'd230;
    vecs[4].t[1] = 9'd231;
    vecs[4].t[2] = 9'd460;
    vecs[4].t[3] = 9'd5;
    fill(5, 15, 1'b1, 511, 289, 1'b1);
    fill(6, 2, 1'b0, 400, 339, 1'b0);

    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_data = 9'd300;
    start = 1'b1;
    n_terms = 4'd3;
    @(negedge clk);
    chk("rst_rdy", int'(bus.in_ready), 0);
    chk("rst_ovalid", int'(bus.out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_odata", int'(bus.out_data), 0);
    chk("rst_err", int'(err), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    start = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", int'(busy), 0);
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      run_job(vecs[i], $sformatf("vec%0d", i));
    end

    // Zero-length job: straight to DONE, never ready for input.
    start = 1'b1;
    n_terms = 4'd0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("zero_ovalid", int'(bus.out_valid), 1);
    chk("zero_odata", int'(bus.out_data), 0);
    chk("zero_rdy", int'(bus.in_ready), 0);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("zero_done", int'(bus.out_valid), 0);

    // Backpressure with start pulses, then start on handshake.
    start = 1'b1;
    n_terms = 4'd1;
    @(posedge clk); #1;
    start = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 9'd7;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      start = c[0] ? 1'b0 : 1'b1;
      n_terms = 4'd5;
      bus.in_valid = 1'b1;
      bus.in_data = 9'd99;
      @(posedge clk); #1;
      chk("bp_ovalid", int'(bus.out_valid), 1);
      chk("bp_odata", int'(bus.out_data), 7);
      chk("bp_rdy", int'(bus.in_ready), 0);
    end
    bus.in_valid = 1'b0;
    start = 1'b1;
    n_terms = 4'd2;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("hs_start_ign_busy", int'(busy), 0);
    chk("hs_start_ign_ov", int'(bus.out_valid), 0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("hs_start_next", int'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.in_data = 9'd10;
    @(posedge clk); #1;
    bus.in_data = 9'd20;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("hs_job_ov", int'(bus.out_valid), 1);
    chk("hs_job_data", int'(bus.out_data), 30);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;

    // Reset mid-job abandons it.
    start = 1'b1;
    n_terms = 4'd4;
    @(posedge clk); #1;
    start = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 9'd100;
    @(posedge clk); #1;
    bus.in_data = 9'd200;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_rdy", int'(bus.in_ready), 0);
    chk("mid_rst_ov", int'(bus.out_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_odata", int'(bus.out_data), 0);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("mid_rst_no_ov", int'(bus.out_valid), 0);
    end
    hv = '0;
    hv.n = 4'd2;
    hv.t[0] = 9'd5;
    hv.t[1] = 9'd6;
    hv.exp_d = 9'd11;
    run_job(hv, "after_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mod461_accum.md
MOD461_ACCUM -- requirements
Module: mod461_accum

Interface
REQ-001 Parameter MOD, 461, modulus for all accumulation arithmetic.
REQ-002 Parameter W, 9, width of residue data paths.
REQ-003 Parameter CNT_W, 4, width of term-count input and internal term counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  begin new accumulation; honoured only in IDLE.
REQ-007 n_terms  input  CNT_W  number of residue terms to sum; sampled when start is honoured.
REQ-008 in_valid  input  1  upstream residue term present.
REQ-009 in_data  input  W  residue term from a 3x3-digit product LUT stage; nominal range 0..MOD-1.
REQ-010 in_ready  output  1  block accepts in_data this cycle.
REQ-011 out_valid  output  1  result available.
REQ-012 out_data  output  W  accumulated sum mod MOD.
REQ-013 out_ready  input  1  downstream consumes result.
REQ-014 busy  output  1  high in ACCUM or DONE.
REQ-015 err  output  1  sticky flag; an out-of-range term (in_data >= MOD) was received in the current job.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, ACCUM, DONE.
REQ-017 IDLE: start=1 with n_terms!=0 -> ACCUM; acc cleared to 0, count loaded with n_terms, err cleared.
REQ-018 IDLE: start=1 with n_terms=0 -> DONE, acc=0, err cleared; out_valid asserts the following cycle.
REQ-019 in_ready SHALL equal 1 only in ACCUM; a term is accepted on in_valid & in_ready.
REQ-020 An accepted term SHALL be pre-reduced: t = in_data-MOD if in_data>=MOD (err set to 1), else t = in_data.
REQ-021 Accumulate: s = acc + t in W+1 bits; acc <= (s >= MOD) ? s-MOD : s; a single conditional subtraction suffices (s <= 920).
REQ-022 Each accepted term SHALL decrement count; the acceptance that takes count from 1 to 0 moves ACCUM -> DONE in the same edge.
REQ-023 Cycles in ACCUM without in_valid SHALL leave acc, count and err unchanged.
REQ-024 DONE: out_valid=1, out_data=acc; held stable while out_ready=0.
REQ-025 DONE with out_ready=1 -> IDLE next edge; out_valid deasserts.
REQ-026 Latency: out_valid SHALL assert on the cycle immediately after the final term is accepted.
REQ-027 start SHALL be ignored in ACCUM and DONE; start asserted on the DONE->IDLE handshake cycle is ignored, and start in the following IDLE cycle is honoured.
REQ-028 out_data SHALL always lie in 0..MOD-1.
REQ-029 err SHALL remain valid through DONE and clear only on the next honoured start or rst.
REQ-030 out_data SHALL be registered (driven directly from acc); no combinational path from in_data to out_data.

Reset
REQ-031 rst=1 SHALL force state IDLE, acc=0, count=0, err=0 on the next edge, overriding all other inputs.
REQ-032 During and immediately after reset, in_ready=0, out_valid=0, busy=0, out_data=0.
REQ-033 rst asserted mid-ACCUM or mid-DONE SHALL abandon the job; no result is emitted for it.

Verification
REQ-034 Wrap: n_terms=3, terms 460,460,1 -> out_data=460, err=0, out_valid one cycle after third accept.
REQ-035 Full length: n_terms=9, nine terms of 100 with random in_valid gaps -> out_data=439 (900 mod 461), err=0.
REQ-036 Zero terms: start with n_terms=0 -> out_valid next cycle, out_data=0, in_ready never asserts.
REQ-037 Out of range: n_terms=2, terms 500,0 -> out_data=39, err=1; err clears on next start.
REQ-038 Backpressure and ignored start: hold out_ready=0 for 5 cycles in DONE while pulsing start -> out_data stable, state stays DONE, no new job begins.
REQ-039 Reset mid-job: n_terms=4, accept 2 terms, assert rst -> IDLE, outputs at reset values, no out_valid; a new job then computes correctly from acc=0.
